alu_exec_unit: RTL and testbench

Execute-stage ALU datapath that consumes the 4-bit ALU control code from the ALU control decoder, together with the two register operands and the shift amount. It produces a registered result with `zero` and `illegal` flags. Logic ops and add/sub/compare complete in one cycle. `SLL` and `SRL` run through an iterative 1-bit-per-cycle shifter, so the unit sits between operand fetch and writeback behind a valid/ready handshake on each side.

---
 rtl/alu_exec_unit.sv | 90 +++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result/flags and an
// iterative 1-bit-per-cycle SLL/SRL, behind valid/ready handshakes.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] alu_res, sreg, sh_next;
    logic [4:0]       cnt;
    logic             dir, ill, is_shift;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign is_shift  = alu_ctrl[3:1] == 3'b100;
    assign sh_next   = dir ? sreg >> 1 : sreg << 1;

    // Shift codes yield op_b here so a zero shift amount completes in one cycle
    always_comb begin
        alu_res = '0;
        ill     = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0011: alu_res = op_a ^ op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b1100: alu_res = ~(op_a | op_b);
            4'b1000, 4'b1001: alu_res = op_b;
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && in_valid)
            state_next = (is_shift && shamt != 5'd0) ? SHIFT : DONE;
        else if (state == SHIFT && cnt == 5'd1)
            state_next = DONE;
        else if (state == DONE && out_ready)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            sreg    <= '0;
            cnt     <= '0;
            dir     <= 1'b0;
        end else begin
            state <= state_next;
            if (in_ready && in_valid) begin
                sreg <= op_b;
                cnt  <= shamt;
                dir  <= alu_ctrl[0];
                if (state_next == DONE) begin
                    result  <= alu_res;
                    zero    <= alu_res == '0;
                    illegal <= ill;
                end
            end else if (state == SHIFT) begin
                sreg <= sh_next;
                cnt  <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    result  <= sh_next;
                    zero    <= sh_next == '0;
                    illegal <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit.
module tb_alu_exec_unit;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [3:0]  alu_ctrl = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic [4:0]  shamt = 0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;
    int          total = 0, bad = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, scrambles the inputs after accept, and returns the
    // accept-to-out_valid latency in cycles plus whether in_ready ever rose.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, output int lat, output bit ready_seen);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        alu_ctrl = c; op_a = a; op_b = b; shamt = s; in_valid = 1;
        tick();
        in_valid = 0; alu_ctrl = 4'b0010; op_a = '1; op_b = '1; shamt = 5'd3;
        lat = 1;
        ready_seen = 0;
        while (!out_valid && lat < 100) begin
            ready_seen |= in_ready;
            tick();
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        total++;
        if (in_ready !== 1 || out_valid !== 0 || result !== 0 || zero !== 0 || illegal !== 0) begin
            bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h zero=%b illegal=%b, want 1 0 0 0 0",
                     in_ready, out_valid, result, zero, illegal);
        end
        rst_n = 1;
    endtask

    task automatic test_add;
        int lat; bit rs;
        do_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, rs);
        total++;
        if (result !== 32'h0 || zero !== 1 || illegal !== 0 || lat != 1) begin
            bad++;
            $display("FAIL add_wrap: result=%h zero=%b illegal=%b lat=%0d, want 00000000 1 0 1",
                     result, zero, illegal, lat);
        end
        consume();
        total++;
        if (out_valid !== 0 || in_ready !== 1) begin
            bad++;
            $display("FAIL consume: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_logic_arith;
        logic [3:0]  c[7]   = '{4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 4'b1100, 4'b0011};
        logic [31:0] a[7]   = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'hFF00_FF00, 32'h0000_00A0, 32'h0, 32'h1234_5678};
        logic [31:0] b[7]   = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0000_0005, 32'h0, 32'h1234_5678};
        logic [31:0] exp[7] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'h0F00_0F00, 32'h0000_00A5, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 7; i++) begin
            int lat; bit rs;
            do_op(c[i], a[i], b[i], 5'd9, lat, rs);
            total++;
            if (result !== exp[i] || zero !== (exp[i] == 0) || illegal !== 0 || lat != 1) begin
                bad++;
                $display("FAIL op[%0d] ctrl=%b: result=%h zero=%b illegal=%b lat=%0d, want %h %b 0 1",
                         i, c[i], result, zero, illegal, lat, exp[i], exp[i] == 0);
            end
            consume();
        end
    endtask

    task automatic test_shift;
        logic [3:0]  c[4]   = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
        logic [31:0] b[4]   = '{32'h1, 32'h8000_0000, 32'h1234, 32'h3};
        logic [4:0]  s[4]   = '{5'd31, 5'd4, 5'd0, 5'd1};
        logic [31:0] exp[4] = '{32'h8000_0000, 32'h0800_0000, 32'h1234, 32'h1};
        int          el[4]  = '{32, 5, 1, 2};
        for (int i = 0; i < 4; i++) begin
            int lat; bit rs;
            do_op(c[i], 32'hDEAD_BEEF, b[i], s[i], lat, rs);
            total++;
            if (result !== exp[i] || zero !== 0 || illegal !== 0 || lat != el[i]) begin
                bad++;
                $display("FAIL shift[%0d]: result=%h zero=%b illegal=%b lat=%0d, want %h 0 0 %0d",
                         i, result, zero, illegal, lat, exp[i], el[i]);
            end
            total++;
            if (rs !== 0) begin
                bad++;
                $display("FAIL shift_in_ready[%0d]: in_ready seen=%b during shift, want 0", i, rs);
            end
            consume();
        end
    endtask

    task automatic test_reset_mid_shift;
        int seen = 0, lat; bit rs;
        alu_ctrl = 4'b1000; op_b = 32'h1; shamt = 5'd20; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        total++;
        if (in_ready !== 0 || out_valid !== 0) begin
            bad++;
            $display("FAIL mid_shift: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
        rst_n = 0;
        #1;
        total++;
        if (in_ready !== 1 || out_valid !== 0 || result !== 0 || zero !== 0 || illegal !== 0) begin
            bad++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h zero=%b illegal=%b, want 1 0 0 0 0",
                     in_ready, out_valid, result, zero, illegal);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_discard: out_valid cycles=%0d after release, want 0", seen);
        end
        do_op(4'b0001, 32'h5, 32'hA, 5'd0, lat, rs);
        total++;
        if (result !== 32'hF || lat != 1) begin
            bad++;
            $display("FAIL after_reset: result=%h lat=%0d, want 0000000f 1", result, lat);
        end
        consume();
    endtask

    task automatic test_illegal;
        logic [3:0] c[2] = '{4'b1111, 4'b0100};
        for (int i = 0; i < 2; i++) begin
            int lat; bit rs;
            do_op(c[i], 32'h1234, 32'h5678, 5'd7, lat, rs);
            total++;
            if (result !== 0 || zero !== 1 || illegal !== 1 || lat != 1) begin
                bad++;
                $display("FAIL illegal[%0d]: result=%h zero=%b illegal=%b lat=%0d, want 0 1 1 1",
                         i, result, zero, illegal, lat);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back;
        int errs = 0;
        out_ready = 1;
        alu_ctrl = 4'b0001; op_a = 32'hA0; op_b = 32'h05; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== (i % 2 == 0) || in_ready !== (i % 2 == 1) ||
                (out_valid && result !== 32'hA5)) errs++;
        end
        in_valid = 0;
        out_ready = 0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL back_to_back: %0d cycles off the IDLE/DONE alternation, want 0", errs);
        end
    endtask

    task automatic test_backpressure;
        int lat, errs = 0; bit rs;
        do_op(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, lat, rs);
        total++;
        if (result !== 32'h0F0F_F0F0 || zero !== 0 || lat != 1) begin
            bad++;
            $display("FAIL xor: result=%h zero=%b lat=%0d, want 0f0ff0f0 0 1", result, zero, lat);
        end
        alu_ctrl = 4'b0010; op_a = 32'd3; op_b = 32'd4; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result !== 32'h0F0F_F0F0 || out_valid !== 1 || in_ready !== 0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stall: %0d stalled cycles changed outputs or raised in_ready, want 0", errs);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        total++;
        if (out_valid !== 0 || in_ready !== 1) begin
            bad++;
            $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 0;
        total++;
        if (out_valid !== 1 || result !== 32'd7 || in_ready !== 0) begin
            bad++;
            $display("FAIL next_accept: out_valid=%b result=%h in_ready=%b, want 1 00000007 0",
                     out_valid, result, in_ready);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_arith();
        test_shift();
        test_reset_mid_shift();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
